// File: rtl/multicycle_control_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_pkg
// Purpose  : Shared types and encodings for the multicycle control unit.
// Revision : 1.0  initial release
// ============================================================================
package multicycle_control_pkg;

    // TRAP exists only when MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN is defined
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
        ,
        TRAP   = 3'd5
`endif
    } state_e;

    localparam logic [3:0] c_op_jump   = 4'd0;
    localparam logic [3:0] c_op_rtype  = 4'd1;
    localparam logic [3:0] c_op_load   = 4'd2;
    localparam logic [3:0] c_op_store  = 4'd3;
    localparam logic [3:0] c_op_branch = 4'd4;

    localparam logic [1:0] c_alu_add   = 2'b00;
    localparam logic [1:0] c_alu_sub   = 2'b01;
    localparam logic [1:0] c_alu_funct = 2'b10;

    localparam logic [1:0] c_pc_seq    = 2'b00;
    localparam logic [1:0] c_pc_branch = 2'b01;
    localparam logic [1:0] c_pc_jump   = 2'b10;

    typedef struct packed {
        logic jump;
        logic rtype;
        logic load;
        logic store;
        logic branch;
        logic illegal;
    } op_class_t;

endpackage
`default_nettype wire

// File: rtl/multicycle_control_decoder.sv
`default_nettype none
// ============================================================================
// Module   : opcode_class_decoder
// Purpose  : Combinational opcode to one-hot instruction class.
// Revision : 1.0  initial release
// ============================================================================
module opcode_class_decoder
    import multicycle_control_pkg::*;
#(
    parameter int OPCODE_W = 4
) (
    input  logic [OPCODE_W-1:0] opcode,
    output op_class_t           op_class
);

    logic       upper_zero;
    logic [3:0] low_nibble;

    always_comb begin
        // any bit above the nibble set makes the opcode illegal
        upper_zero = ((opcode >> 4) == '0);
        low_nibble = opcode[3:0];
        op_class   = '0;
        if (upper_zero) begin
            case (low_nibble)
                c_op_jump:   op_class.jump    = 1'b1;
                c_op_rtype:  op_class.rtype   = 1'b1;
                c_op_load:   op_class.load    = 1'b1;
                c_op_store:  op_class.store   = 1'b1;
                c_op_branch: op_class.branch  = 1'b1;
                default:     op_class.illegal = 1'b1;
            endcase
        end else begin
            op_class.illegal = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Purpose  : FSM controller for a multicycle datapath with memory timeout.
//            Define MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN to trap illegal opcodes.
// Revision : 1.0  initial release
// ============================================================================
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int OPCODE_W     = 4,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    input  logic                zero,
    output logic                pc_write,
    output logic                ir_write,
    output logic                reg_write,
    output logic                mem_read,
    output logic                mem_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                alu_src,
    output logic [1:0]          alu_op,
    output logic [1:0]          pc_src,
    output logic                instr_done,
    output logic                mem_timeout,
    output logic                illegal
);

    localparam int             CNT_W        = $clog2(MEM_WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] c_wait_limit = CNT_W'(MEM_WAIT_MAX);

    state_e              state_q, state_d;
    logic [OPCODE_W-1:0] op_q, op_d;
    logic [CNT_W-1:0]    wait_q, wait_d;

    op_class_t dec_live;
    op_class_t dec_held;
    logic      wait_expired;
    logic      unused_held_class;

    opcode_class_decoder #(.OPCODE_W(OPCODE_W)) u_dec_live (
        .opcode   (opcode),
        .op_class (dec_live)
    );

    opcode_class_decoder #(.OPCODE_W(OPCODE_W)) u_dec_held (
        .opcode   (op_q),
        .op_class (dec_held)
    );

    // jump/illegal never leave DECODE, so the held copy ignores them
    assign unused_held_class = dec_held.jump | dec_held.illegal;
    assign wait_expired      = (wait_q == c_wait_limit);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= FETCH;
            op_q    <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        wait_d      = '0;
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src     = 1'b0;
        alu_op      = c_alu_add;
        pc_src      = c_pc_seq;
        instr_done  = 1'b0;
        mem_timeout = 1'b0;
        illegal     = 1'b0;

        case (state_q)
            FETCH: begin
                // mem_ready is tested first so it beats a same-cycle timeout
                if (mem_ready) begin
                    mem_read = 1'b1;
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    pc_src   = c_pc_seq;
                    state_d  = DECODE;
                end else if (wait_expired) begin
                    mem_timeout = 1'b1;
                    state_d     = FETCH;
                end else begin
                    mem_read = 1'b1;
                    wait_d   = wait_q + CNT_W'(1);
                end
            end

            DECODE: begin
                op_d = opcode;
                if (dec_live.jump) begin
                    pc_write   = 1'b1;
                    pc_src     = c_pc_jump;
                    instr_done = 1'b1;
                    state_d    = FETCH;
                end
                if (dec_live.rtype | dec_live.load | dec_live.store | dec_live.branch) begin
                    state_d = EXEC;
                end
                if (dec_live.illegal) begin
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
                    state_d = TRAP;
`else
                    instr_done = 1'b1;
                    state_d    = FETCH;
`endif
                end
            end

            EXEC: begin
                if (dec_held.rtype) begin
                    alu_op  = c_alu_funct;
                    state_d = WB;
                end else if (dec_held.load | dec_held.store) begin
                    alu_op  = c_alu_add;
                    alu_src = 1'b1;
                    state_d = MEM;
                end else if (dec_held.branch) begin
                    alu_op     = c_alu_sub;
                    pc_src     = c_pc_branch;
                    pc_write   = zero;
                    instr_done = 1'b1;
                    state_d    = FETCH;
                end else begin
                    state_d = FETCH;
                end
            end

            MEM: begin
                if (mem_ready) begin
                    mem_read  = dec_held.load;
                    mem_write = dec_held.store;
                    if (dec_held.store) begin
                        instr_done = 1'b1;
                        state_d    = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end else if (wait_expired) begin
                    mem_timeout = 1'b1;
                    state_d     = FETCH;
                end else begin
                    mem_read  = dec_held.load;
                    mem_write = dec_held.store;
                    wait_d    = wait_q + CNT_W'(1);
                end
            end

            WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                reg_dst    = dec_held.rtype;
                mem_to_reg = dec_held.load;
                state_d    = FETCH;
            end

`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
            TRAP: begin
                illegal = 1'b1;
                state_d = TRAP;
            end
`endif

            default: state_d = FETCH;
        endcase

        // outputs are forced quiet for the whole reset cycle
        if (reset) begin
            pc_write    = 1'b0;
            ir_write    = 1'b0;
            reg_write   = 1'b0;
            mem_read    = 1'b0;
            mem_write   = 1'b0;
            reg_dst     = 1'b0;
            mem_to_reg  = 1'b0;
            alu_src     = 1'b0;
            alu_op      = 2'b00;
            pc_src      = 2'b00;
            instr_done  = 1'b0;
            mem_timeout = 1'b0;
            illegal     = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control
// Purpose  : Randomized self-checking bench with an instruction-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_multicycle_control;

    localparam int OPCODE_W     = 6;
    localparam int MEM_WAIT_MAX = 15;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       instr_done;
        logic       mem_timeout;
        logic       illegal;
    } outs_t;

    logic                clock = 1'b0;
    logic                reset;
    logic [OPCODE_W-1:0] opcode;
    logic                mem_ready;
    logic                zero;
    logic                pc_write, ir_write, reg_write, mem_read, mem_write;
    logic                reg_dst, mem_to_reg, alu_src;
    logic [1:0]          alu_op, pc_src;
    logic                instr_done, mem_timeout, illegal;
    outs_t               dut_vec;

    multicycle_control #(.OPCODE_W(OPCODE_W), .MEM_WAIT_MAX(MEM_WAIT_MAX)) dut (
        .clock       (clock),
        .reset       (reset),
        .opcode      (opcode),
        .mem_ready   (mem_ready),
        .zero        (zero),
        .pc_write    (pc_write),
        .ir_write    (ir_write),
        .reg_write   (reg_write),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .alu_src     (alu_src),
        .alu_op      (alu_op),
        .pc_src      (pc_src),
        .instr_done  (instr_done),
        .mem_timeout (mem_timeout),
        .illegal     (illegal)
    );

    assign dut_vec = {pc_write, ir_write, reg_write, mem_read, mem_write, reg_dst,
                      mem_to_reg, alu_src, alu_op, pc_src, instr_done, mem_timeout, illegal};

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int done_cyc = 0;
    int tmo_cyc  = 0;
    int cnt_mem_read = 0, cnt_mem_write = 0, cnt_ir_write = 0, cnt_pc_write = 0;
    int cnt_timeout = 0, cnt_reg_write = 0, cnt_done = 0, cnt_illegal = 0;

    // 0 random, 1 always ready, 2 never ready, 3 ready after N waits, 4 ready only in fetch
    int ready_mode  = 0;
    int ready_after = 0;
    int zero_mode   = -1;

    task automatic step(input outs_t e, input string tag);
        @(negedge clock);
        cyc++;
        n_checks++;
        if (dut_vec === e) n_pass++;
        else $display("FAIL %s cycle %0d: got %b, required %b", tag, cyc, dut_vec, e);
        if (dut_vec.mem_read    === 1'b1) cnt_mem_read++;
        if (dut_vec.mem_write   === 1'b1) cnt_mem_write++;
        if (dut_vec.ir_write    === 1'b1) cnt_ir_write++;
        if (dut_vec.pc_write    === 1'b1) cnt_pc_write++;
        if (dut_vec.reg_write   === 1'b1) cnt_reg_write++;
        if (dut_vec.illegal     === 1'b1) cnt_illegal++;
        if (dut_vec.instr_done  === 1'b1) begin cnt_done++; done_cyc = cyc; end
        if (dut_vec.mem_timeout === 1'b1) begin cnt_timeout++; tmo_cyc = cyc; end
        @(posedge clock);
        #1;
    endtask

    task automatic check_lit(input string tag, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", tag, act, req);
    endtask

    task automatic drive_noise();
        opcode = OPCODE_W'($urandom);
        zero   = 1'($urandom);
    endtask

    function automatic logic pick_ready(input int kind, input int waited);
        case (ready_mode)
            1:       return 1'b1;
            2:       return 1'b0;
            3:       return (waited >= ready_after);
            4:       return (kind == 0);
            default: return ($urandom_range(0, 2) == 0);
        endcase
    endfunction

    task automatic apply_reset(input logic rdy);
        outs_t e;
        e = '0;
        drive_noise();
        reset     = 1'b1;
        mem_ready = rdy;
        step(e, "reset_cycle");
        reset = 1'b0;
    endtask

    // kind: 0 instruction fetch, 1 load access, 2 store access
    task automatic wait_mem(input int kind, output bit ok);
        outs_t e;
        int    waited;
        waited = 0;
        forever begin
            drive_noise();
            mem_ready = pick_ready(kind, waited);
            e = '0;
            if (mem_ready) begin
                if (kind == 0) begin e.mem_read = 1; e.ir_write = 1; e.pc_write = 1; end
                else if (kind == 1) e.mem_read = 1;
                else begin e.mem_write = 1; e.instr_done = 1; end
                step(e, "mem_ready");
                ok = 1'b1;
                return;
            end else if (waited == MEM_WAIT_MAX) begin
                e.mem_timeout = 1;
                step(e, "mem_timeout");
                ok = 1'b0;
                return;
            end else begin
                if (kind == 2) e.mem_write = 1; else e.mem_read = 1;
                step(e, "mem_wait");
                waited++;
            end
        end
    endtask

`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
    task automatic sit_in_trap(input int n);
        outs_t e;
        e = '0;
        e.illegal = 1;
        repeat (n) begin
            drive_noise();
            mem_ready = 1'($urandom);
            step(e, "trap");
        end
        apply_reset(1'b1);
    endtask
`endif

    task automatic run_instr(input int opc);
        outs_t e;
        bit    ok;
        wait_mem(0, ok);
        if (!ok) return;

        opcode    = OPCODE_W'(opc);
        zero      = 1'($urandom);
        mem_ready = 1'($urandom);
        e = '0;
        if (opc == 0) begin
            e.pc_write = 1; e.pc_src = 2'b10; e.instr_done = 1;
        end else if (opc > 4) begin
`ifndef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
            e.instr_done = 1;
`endif
        end
        step(e, "decode");
        if (opc > 4) begin
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
            sit_in_trap(5);
`endif
            return;
        end
        if (opc == 0) return;

        drive_noise();
        mem_ready = 1'($urandom);
        if (zero_mode >= 0) zero = 1'(zero_mode);
        e = '0;
        case (opc)
            1: e.alu_op = 2'b10;
            2, 3: e.alu_src = 1;
            default: begin
                e.alu_op = 2'b01; e.pc_src = 2'b01; e.pc_write = zero; e.instr_done = 1;
            end
        endcase
        step(e, "exec");
        if (opc == 4) return;

        if (opc != 1) begin
            wait_mem((opc == 2) ? 1 : 2, ok);
            if (!ok || opc == 3) return;
        end

        drive_noise();
        mem_ready = 1'($urandom);
        e = '0;
        e.reg_write = 1; e.instr_done = 1;
        if (opc == 1) e.reg_dst = 1; else e.mem_to_reg = 1;
        step(e, "writeback");
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int    s, m0, m1, m2, m3;
        bit    ok;
        outs_t e;

        reset = 1'b1; mem_ready = 1'b1; opcode = 6'd2; zero = 1'b1;
        e = '0;
        step(e, "reset_initial");
        step(e, "reset_hold");
        reset = 1'b0;

        // R-type, memory always ready: instr_done on the 4th cycle
        ready_mode = 1;
        s = cyc; m0 = cnt_reg_write;
        run_instr(1);
        check_lit("rtype_done_cycle", done_cyc - s, 4);
        check_lit("rtype_reg_write", cnt_reg_write - m0, 1);

        // lw with three not-ready cycles in both fetch and MEM
        ready_mode = 3; ready_after = 3;
        s = cyc; m0 = cnt_mem_read;
        run_instr(2);
        check_lit("lw_mem_read_cycles", cnt_mem_read - m0, 8);
        check_lit("lw_done_cycle", done_cyc - s, 11);

        // branch taken / not taken
        ready_mode = 1;
        zero_mode = 1; m0 = cnt_pc_write;
        run_instr(4);
        check_lit("branch_taken_pc_writes", cnt_pc_write - m0, 2);
        zero_mode = 0; m0 = cnt_pc_write;
        run_instr(4);
        check_lit("branch_not_taken_pc_writes", cnt_pc_write - m0, 1);
        zero_mode = -1;

        // fetch never ready: 15 wait cycles, then the timeout pulse
        ready_mode = 2;
        s = cyc; m0 = cnt_mem_read; m1 = cnt_timeout; m2 = cnt_ir_write;
        run_instr(1);
        check_lit("fetch_timeout_reads", cnt_mem_read - m0, 15);
        check_lit("fetch_timeout_pulses", cnt_timeout - m1, 1);
        check_lit("fetch_timeout_cycle", tmo_cyc - s, 16);
        check_lit("fetch_timeout_ir_write", cnt_ir_write - m2, 0);
        ready_mode = 1;
        s = cyc;
        run_instr(1);
        check_lit("after_timeout_rtype_done", done_cyc - s, 4);

        // lw whose MEM access never completes
        ready_mode = 4;
        m0 = cnt_timeout; m1 = cnt_reg_write;
        run_instr(2);
        check_lit("mem_timeout_pulses", cnt_timeout - m0, 1);
        check_lit("mem_timeout_no_reg_write", cnt_reg_write - m1, 0);

        // illegal opcodes: plain 9 and one with an upper bit set
        ready_mode = 1;
        m0 = cnt_done; m1 = cnt_illegal;
        run_instr(9);
        run_instr(17);
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
        check_lit("illegal_done_pulses", cnt_done - m0, 0);
        check_lit("illegal_trap_cycles", cnt_illegal - m1, 10);
`else
        check_lit("illegal_done_pulses", cnt_done - m0, 2);
        check_lit("illegal_flag_cycles", cnt_illegal - m1, 0);
`endif

        // reset while a store sits in MEM
        ready_mode = 1;
        wait_mem(0, ok);
        opcode = 6'd3; mem_ready = 1'b0;
        e = '0;
        step(e, "sw_decode");
        drive_noise(); mem_ready = 1'b0;
        e = '0; e.alu_src = 1;
        step(e, "sw_exec");
        m0 = cnt_mem_write;
        apply_reset(1'b0);
        check_lit("sw_reset_mem_write", cnt_mem_write - m0, 0);
        s = cyc;
        run_instr(1);
        check_lit("post_reset_rtype_done", done_cyc - s, 4);

        // randomized instruction stream
        for (int i = 0; i < 300; i++) begin
            int r, opc;
            r = $urandom_range(0, 19);
            ready_mode = (r < 16) ? 0 : (r < 18) ? 4 : (r == 18) ? 2 : 1;
            r = $urandom_range(0, 5);
            opc = (r < 5) ? r : $urandom_range(5, 63);
            m3 = cyc;
            run_instr(opc);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
